// File: rtl/ak_cmd_dispatch.sv
// Command sequencer between the AK register file and its decoders: latches a command,
// issues it over a per-type req/ack handshake with a timeout, and reports the response.
module ak_cmd_dispatch #(
    parameter int NUM_DEC_TYPES  = 4,
    parameter int NUM_DEC_INST   = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    input  logic [7:0]                  cmd_route,
    input  logic [31:0]                 cmd_code,
    input  logic [31:0]                 cmd_data,
    input  logic                        flag_clr,
    output logic                        cmd_busy,
    output logic [NUM_DEC_TYPES-1:0]    dec_req,
    output logic [3:0]                  dec_inst,
    output logic [31:0]                 dec_code,
    output logic [31:0]                 dec_wdata,
    input  logic [NUM_DEC_TYPES-1:0]    dec_ack,
    input  logic [32*NUM_DEC_TYPES-1:0] dec_rdata,
    output logic                        resp_valid,
    output logic [31:0]                 resp_data,
    output logic [1:0]                  resp_status,
    output logic                        resp_flag,
    output logic                        cmd_overrun
);

    localparam int          TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TYPES_U    = NUM_DEC_TYPES;
    localparam logic [31:0] INST_U     = NUM_DEC_INST;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_BAD     = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state;
    logic [3:0]                 dec_type;
    logic [TW-1:0]              timer;

    logic                       route_ok;
    logic [NUM_DEC_TYPES-1:0]   new_req;
    logic                       sel_ack;
    logic [31:0]                sel_rdata;
    logic                       done_next;

    always_comb begin
        route_ok = ({28'd0, cmd_route[7:4]} < TYPES_U) && ({28'd0, cmd_route[3:0]} < INST_U);
        new_req  = '0;
        for (int t = 0; t < NUM_DEC_TYPES; t++) begin
            new_req[t] = (cmd_route[7:4] == 4'(t));
        end
    end

    // Only the ack and response word of the latched type matter; other acks are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = 32'd0;
        for (int t = 0; t < NUM_DEC_TYPES; t++) begin
            if (dec_type == 4'(t)) begin
                sel_ack   = dec_ack[t];
                sel_rdata = dec_rdata[32*t +: 32];
            end
        end
    end

    assign done_next = ((state == IDLE) && cmd_valid && !route_ok) ||
                       ((state == WAIT) && (sel_ack || (timer == TIMER_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dec_type    <= 4'd0;
            timer       <= '0;
            cmd_busy    <= 1'b0;
            dec_req     <= '0;
            dec_inst    <= 4'd0;
            dec_code    <= 32'd0;
            dec_wdata   <= 32'd0;
            resp_valid  <= 1'b0;
            resp_data   <= 32'd0;
            resp_status <= 2'd0;
            resp_flag   <= 1'b0;
            cmd_overrun <= 1'b0;
        end else begin
            resp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dec_type  <= cmd_route[7:4];
                        dec_inst  <= cmd_route[3:0];
                        dec_code  <= cmd_code;
                        dec_wdata <= cmd_data;
                        timer     <= '0;
                        cmd_busy  <= 1'b1;
                        if (route_ok) begin
                            dec_req <= new_req;
                            state   <= WAIT;
                        end else begin
                            resp_valid  <= 1'b1;
                            resp_status <= ST_BAD;
                            resp_data   <= 32'h0000_0000;
                            state       <= DONE;
                        end
                    end
                end

                // Ack is checked first so an ack on the last allowed cycle still counts.
                WAIT: begin
                    if (sel_ack) begin
                        dec_req     <= '0;
                        resp_valid  <= 1'b1;
                        resp_status <= ST_OK;
                        resp_data   <= sel_rdata;
                        state       <= DONE;
                    end else if (timer == TIMER_LAST) begin
                        dec_req     <= '0;
                        resp_valid  <= 1'b1;
                        resp_status <= ST_TIMEOUT;
                        resp_data   <= 32'hFFFF_FFFF;
                        state       <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DONE: begin
                    cmd_busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    dec_req  <= '0;
                    cmd_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase

            // Setting the flag (entering or sitting in DONE) beats both clear sources.
            if (done_next || (state == DONE)) begin
                resp_flag <= 1'b1;
            end else if ((state == IDLE) && cmd_valid) begin
                resp_flag <= 1'b0;
            end else if (flag_clr) begin
                resp_flag <= 1'b0;
            end

            if (cmd_valid && (state != IDLE)) begin
                cmd_overrun <= 1'b1;
            end else if (flag_clr) begin
                cmd_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ak_cmd_dispatch.md
# ak_cmd_dispatch

Command sequencer between the AK control register file and the decoder instances it configures. Software writes route, code and data words; the data write pulses `cmd_valid`. The block latches the command, issues it to the addressed decoder type/instance over a req/ack handshake, and guards it with a timeout. It then returns the response word and status to the register file and sets the sticky response-ready flag that software polls at regfile offset 5.

## Interface
- `NUM_DEC_TYPES`, 4, number of decoder types; width of the one-hot request/ack vectors.
- `NUM_DEC_INST`, 8, instances per type; routes with `dec_inst >= NUM_DEC_INST` are invalid.
- `TIMEOUT_CYCLES`, 65535, maximum cycles `dec_req` is held waiting for ack (legal range ≥2).

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  one-cycle pulse when regfile `e_cmd_dat_resp` is written.
- `cmd_route`  in  8  [7:4] dec_type, [3:0] dec_inst (regfile `e_cmd_route`).
- `cmd_code`  in  32  command code (regfile `e_cmd_code`), passed through uninterpreted.
- `cmd_data`  in  32  command data word.
- `flag_clr`  in  1  pulse; clears `resp_flag` and `cmd_overrun`.
- `cmd_busy`  out  1  high from the cycle after acceptance until return to IDLE.
- `dec_req`  out  NUM_DEC_TYPES  one-hot level request to the selected type.
- `dec_inst`  out  4  latched instance select.
- `dec_code`  out  32  latched command code.
- `dec_wdata`  out  32  latched command data.
- `dec_ack`  in  NUM_DEC_TYPES  per-type one-cycle acknowledge.
- `dec_rdata`  in  32*NUM_DEC_TYPES  per-type response word; type t is at [32t+31:32t].
- `resp_valid`  out  1  one-cycle pulse when a response is written back.
- `resp_data`  out  32  response word; held until the next response.
- `resp_status`  out  2  0 OK, 1 TIMEOUT, 2 BAD_ROUTE; held with `resp_data`.
- `resp_flag`  out  1  sticky response-ready flag (offset 5).
- `cmd_overrun`  out  1  sticky; set when a command arrives while busy.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset enters IDLE.
- **IDLE, `cmd_valid`=1:**
  - Latch route, code and data, and clear `resp_flag`.
  - Valid route (`dec_type < NUM_DEC_TYPES` and `dec_inst < NUM_DEC_INST`): go to WAIT, set `dec_req[dec_type]`, clear the timer.
  - Invalid route: go to DONE with status BAD_ROUTE and `resp_data` = 0x0000_0000. No request is issued.
- **WAIT:**
  - `dec_req` is held high.
  - `dec_ack[dec_type]`=1: capture the selected `dec_rdata` slice, status OK, drop `dec_req`, go to DONE.
  - Otherwise the timer increments. When the timer equals `TIMEOUT_CYCLES-1` with no ack: status TIMEOUT, `resp_data` = 0xFFFF_FFFF, drop `dec_req`, go to DONE.
  - Acks from non-selected types are ignored.
- **DONE** (one cycle): `resp_valid`=1, `resp_flag` set, then go to IDLE.
- **`cmd_valid` while not IDLE:** the command is dropped and `cmd_overrun` is set. The in-flight command is unaffected.
- **Simultaneous events:**
  - Ack and timeout in the same cycle: ack wins.
  - `flag_clr` and flag set in the same cycle: set wins.
  - `cmd_valid` in IDLE together with `flag_clr`: the flag stays cleared.
- **`rst` mid-transaction:** abandon the transaction; no response is produced.
- **Reset values:**
  - State IDLE.
  - `cmd_busy`, `dec_req`, `resp_valid`, `resp_flag`, `cmd_overrun` = 0.
  - `dec_inst`, `dec_code`, `dec_wdata`, `resp_data`, `resp_status` = 0.
  - Timer = 0.

## Timing
- All outputs are registered.
- Valid command sampled in cycle 0:
  - Cycle 1: `dec_req` high and `cmd_busy`=1.
  - Ack sampled in cycle k (k≥1): `dec_req` low in cycle k+1, and `resp_valid`/`resp_status`/`resp_data` and `resp_flag` rise in k+1.
  - Cycle k+2: `cmd_busy`=0, and the next `cmd_valid` is accepted.
- Timeout: `dec_req` is high for exactly `TIMEOUT_CYCLES` cycles (1..T), and `resp_valid` pulses in cycle T+1.
- Bad route: `resp_valid` pulses in cycle 1 and `cmd_busy`=0 in cycle 2. `cmd_busy` is high in cycle 1.
- Minimum command spacing: 3 cycles with an ack in cycle 1.
- `resp_flag` stays high until the next accepted command or `flag_clr`.

## Test plan
- **Normal command:** route 0x23, code 0x27, data 0x3333_3327; type 2 acks 5 cycles after `dec_req` with rdata 0x1234_5678.
  - `dec_req`=4'b0100 for cycles 1–5, with `dec_inst`=3, `dec_code`=0x27, `dec_wdata`=0x3333_3327.
  - Cycle 6: `resp_valid`, `resp_data`=0x1234_5678, status 0, `resp_flag`=1.
- **Timeout:** `TIMEOUT_CYCLES`=16, route 0x10, no ack.
  - `dec_req[1]` is high for exactly 16 cycles.
  - Cycle 17: `resp_data`=0xFFFF_FFFF, status 1.
  - A late ack in cycle 20 is ignored.
- **Bad route:** route 0x53 (type 5 ≥ 4), then separately route 0x0A (inst 10 ≥ 8).
  - `dec_req` is never asserted.
  - Cycle 1: `resp_valid`, status 2, `resp_data`=0.
- **Overrun and wrong-type ack:** command to type 0; second `cmd_valid` in cycle 3; type 1 acks in cycle 2; type 0 acks in cycle 4.
  - `cmd_overrun`=1, the type 1 ack is ignored, and only one response is produced (type 0 rdata, cycle 5).
  - `flag_clr` clears `cmd_overrun` and `resp_flag`.
- **Races and back-to-back:**
  - Ack exactly at cycle T with `TIMEOUT_CYCLES`=T=8 → status OK.
  - `flag_clr` in the DONE cycle → `resp_flag`=1.
  - Back-to-back stream of 11 commands with code 0x27..0x31 and ack in 1 cycle → 11 responses with no overrun.
- **Reset mid-WAIT:** assert `rst` in cycle 3 of WAIT.
  - Next cycle: all outputs at reset values, no `resp_valid`.
  - A subsequent command completes normally.
